// File: rtl/mux_scan_if.sv
// Handshake/bus bundle between the scan serializer and its mux + consumer.
// The serializer uses the slave modport; the environment driving it uses master.
interface mux_scan_if;
    logic       start_i;
    logic       y_i;
    logic       out_ready_i;
    logic [2:0] sel_o;
    logic       busy_o;
    logic       out_valid_o;
    logic [7:0] data_out_o;

    modport slave (
        input  start_i,
        input  y_i,
        input  out_ready_i,
        output sel_o,
        output busy_o,
        output out_valid_o,
        output data_out_o
    );

    modport master (
        output start_i,
        output y_i,
        output out_ready_i,
        input  sel_o,
        input  busy_o,
        input  out_valid_o,
        input  data_out_o
    );
endinterface

// File: rtl/mux_scan_serializer.sv
// Walks an 8:1 mux through select codes 0..7, samples y once per code and offers
// the eight samples as one byte {a..h} on a valid/ready output.
//
// state | meaning
// IDLE  | waiting for start; data_out holds the last word
// SCAN  | stepping sel, sampling y on the last cycle of each code
// DONE  | word valid, waiting for out_ready
module mux_scan_serializer #(
    parameter int unsigned SETTLE = 1,
    parameter bit          AUTO   = 1'b0
) (
    input  logic      clk_i,
    input  logic      rst_i,
    mux_scan_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    state_t     state_q, state_d;
    logic [2:0] sel_q,   sel_d;
    logic [3:0] cnt_q,   cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] data_q,  data_d;
    logic       valid_q, valid_d;
    logic       busy_q,  busy_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            sel_q   <= 3'd0;
            cnt_q   <= 4'd0;
            shreg_q <= 8'd0;
            data_q  <= 8'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = valid_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    state_d = ST_SCAN;
                    sel_d   = 3'd0;
                    cnt_d   = 4'd0;
                    shreg_d = 8'd0;
                end
            end
            ST_SCAN: begin
                if (cnt_q == SETTLE_C) begin
                    cnt_d   = 4'd0;
                    shreg_d = {shreg_q[6:0], bus.y_i};
                    // sel wraps 7 -> 0 on its own when the last code completes
                    sel_d   = sel_q + 3'd1;
                    if (sel_q == 3'd7) begin
                        data_d  = {shreg_q[6:0], bus.y_i};
                        valid_d = 1'b1;
                        state_d = ST_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_DONE: begin
                if (valid_q && bus.out_ready_i) begin
                    valid_d = 1'b0;
                    if (AUTO) begin
                        state_d = ST_SCAN;
                        sel_d   = 3'd0;
                        cnt_d   = 4'd0;
                        shreg_d = 8'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = 3'd0;
                cnt_d   = 4'd0;
                valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign bus.sel_o       = sel_q;
    assign bus.busy_o      = busy_q;
    assign bus.out_valid_o = valid_q;
    assign bus.data_out_o  = data_q;

endmodule
